// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared state encoding, defaults and width helpers for the SAD search controller
package sad_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_NUM_CAND = 16;
    localparam int DEF_PIPE_LAT = 3;
    localparam int SAD_MARGIN   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic int sad_width(input int w);
        return w + SAD_MARGIN;
    endfunction

    // A single-candidate search still needs a one-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sad_tag_pipe.sv
// rtl/sad_tag_pipe.sv - valid/index tag delay line that tracks candidates through the SAD datapath
module sad_tag_pipe #(
    parameter int PIPE_LAT = 3,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [PIPE_LAT-1:0] valid;
    logic [IDX_W-1:0]    idx [PIPE_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                idx[i] <= '0;
            end
        end else if (shift) begin
            valid[0] <= in_valid;
            idx[0]   <= in_idx;
            for (int i = 1; i < PIPE_LAT; i++) begin
                valid[i] <= valid[i-1];
                idx[i]   <= idx[i-1];
            end
        end
    end

    assign out_valid = valid[PIPE_LAT-1];
    assign out_idx   = idx[PIPE_LAT-1];

endmodule

// File: rtl/sad_search_ctrl.sv
// rtl/sad_search_ctrl.sv - sequences a SAD datapath over all candidates and tracks the minimum
module sad_search_ctrl
    import sad_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_CAND = DEF_NUM_CAND,
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    parameter int SAD_W    = sad_width(WIDTH),
    localparam int IDX_W   = idx_width(NUM_CAND)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             ack,
    input  logic [SAD_W-1:0] sad_in,
    output logic             sad_en,
    output logic             sad_rst,
    output logic [IDX_W-1:0] cand_idx,
    output logic             busy,
    output logic             done,
    output logic [SAD_W-1:0] best_sad,
    output logic [IDX_W-1:0] best_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CAND - 1);
    localparam logic [3:0]       DRAIN_TOP = 4'(PIPE_LAT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       drain_cnt;
    logic             tag_valid;
    logic [IDX_W-1:0] tag_idx;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (init) state_nxt = ST_CLEAR;
            ST_CLEAR: state_nxt = ST_ISSUE;
            ST_ISSUE: if (cand_idx == LAST_IDX) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == 4'd0) state_nxt = ST_DONE;
            ST_DONE:  if (ack) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            sad_en    <= 1'b0;
            sad_rst   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cand_idx  <= '0;
            drain_cnt <= 4'd0;
            best_sad  <= '1;
            best_idx  <= '0;
        end else begin
            state   <= state_nxt;
            sad_en  <= (state_nxt == ST_ISSUE) || (state_nxt == ST_DRAIN);
            sad_rst <= (state_nxt == ST_CLEAR);
            busy    <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
            done    <= (state_nxt == ST_DONE);

            if (state == ST_IDLE && init) begin
                cand_idx <= '0;
            end else if (state == ST_ISSUE && cand_idx != LAST_IDX) begin
                cand_idx <= cand_idx + 1'b1;
            end

            if (state == ST_ISSUE) begin
                drain_cnt <= DRAIN_TOP;
            end else if (state == ST_DRAIN && drain_cnt != 4'd0) begin
                drain_cnt <= drain_cnt - 4'd1;
            end

            // Strict less-than keeps the lowest index on ties.
            if (state == ST_IDLE && init) begin
                best_sad <= '1;
                best_idx <= '0;
            end else if (sad_en && tag_valid && (sad_in < best_sad)) begin
                best_sad <= sad_in;
                best_idx <= tag_idx;
            end
        end
    end

    sad_tag_pipe #(
        .PIPE_LAT (PIPE_LAT),
        .IDX_W    (IDX_W)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .shift     (sad_en),
        .in_valid  (state == ST_ISSUE),
        .in_idx    (cand_idx),
        .out_valid (tag_valid),
        .out_idx   (tag_idx)
    );

endmodule

// File: tb/tb_sad_search_ctrl.sv
// tb/tb_sad_search_ctrl.sv - randomized self-checking bench for sad_search_ctrl
module tb_sad_search_ctrl;

    localparam int N  = 16;
    localparam int P  = 3;
    localparam int SW = 13;
    localparam int ALL_ONES = 8191;

    logic          clk = 1'b0;
    logic          rst;
    logic          init, ack;
    logic [SW-1:0] sad_in;
    logic          sad_en, sad_rst, busy, done;
    logic [3:0]    cand_idx, best_idx;
    logic [SW-1:0] best_sad;

    logic          init1, ack1;
    logic [SW-1:0] sad_in1;
    logic          sad_en1, sad_rst1, busy1, done1;
    logic [0:0]    cand_idx1, best_idx1;
    logic [SW-1:0] best_sad1;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    int            sadv [N];
    logic [SW-1:0] slot [64];
    bit            slot_v [64];
    int            slot_now, slot_fut;
    int            rst_pulses = 0;
    int            en_cycles  = 0;
    logic [SW-1:0] pend1;
    bit            pend1_v = 1'b0;

    sad_search_ctrl #(.WIDTH(8), .NUM_CAND(N), .PIPE_LAT(P)) dut (
        .clk(clk), .rst(rst), .init(init), .ack(ack), .sad_in(sad_in),
        .sad_en(sad_en), .sad_rst(sad_rst), .cand_idx(cand_idx), .busy(busy),
        .done(done), .best_sad(best_sad), .best_idx(best_idx)
    );

    sad_search_ctrl #(.WIDTH(8), .NUM_CAND(1), .PIPE_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .init(init1), .ack(ack1), .sad_in(sad_in1),
        .sad_en(sad_en1), .sad_rst(sad_rst1), .cand_idx(cand_idx1), .busy(busy1),
        .done(done1), .best_sad(best_sad1), .best_idx(best_idx1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Datapath stand-in: a candidate enabled in cycle c returns its SAD in cycle c+P; junk otherwise.
    always @(negedge clk) begin
        slot_now = cyc % 64;
        sad_in = slot_v[slot_now] ? slot[slot_now] : SW'($urandom);
        slot_v[slot_now] = 1'b0;
        if (sad_en) begin
            slot_fut = (cyc + P) % 64;
            slot[slot_fut]   = SW'(sadv[cand_idx]);
            slot_v[slot_fut] = 1'b1;
            en_cycles++;
        end
        if (sad_rst) rst_pulses++;
        sad_in1 = pend1_v ? pend1 : SW'($urandom);
        pend1_v = sad_en1;
        pend1   = SW'(42);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic void model_best(output int bv, output int bi);
        bv = sadv[0];
        bi = 0;
        for (int k = 1; k < N; k++) begin
            if (sadv[k] < bv) begin
                bv = sadv[k];
                bi = k;
            end
        end
    endfunction

    task automatic run_main(input string tag, input bit hold_init);
        int n, bv, bi;
        model_best(bv, bi);
        @(negedge clk);
        rst_pulses = 0;
        en_cycles  = 0;
        init = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        if (!hold_init) init = 1'b0;
        while (!done && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, "_latency"}, n, 2 + N + P);
        check({tag, "_best_sad"}, best_sad, bv);
        check({tag, "_best_idx"}, best_idx, bi);
        check({tag, "_cand_hold"}, cand_idx, N - 1);
        check({tag, "_sad_rst_pulses"}, rst_pulses, 1);
        check({tag, "_en_cycles"}, en_cycles, N + P);
        check({tag, "_busy_in_done"}, busy, 0);
    endtask

    task automatic do_ack(input string tag);
        logic [SW-1:0] keep_sad;
        logic [3:0]    keep_idx;
        keep_sad = best_sad;
        keep_idx = best_idx;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check({tag, "_ack_done"}, done, 0);
        check({tag, "_ack_busy"}, busy, 0);
        check({tag, "_keep_sad"}, best_sad, keep_sad);
        check({tag, "_keep_idx"}, best_idx, keep_idx);
    endtask

    initial begin
        int n;
        rst = 1'b1; init = 1'b0; ack = 1'b0; init1 = 1'b0; ack1 = 1'b0;
        for (int k = 0; k < N; k++) sadv[k] = 0;
        #1 rst = 1'b0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sad_en", sad_en, 0);
        check("reset_sad_rst", sad_rst, 0);
        check("reset_cand_idx", cand_idx, 0);
        check("reset_best_sad", best_sad, ALL_ONES);
        check("reset_best_idx", best_idx, 0);
        check("reset_best_sad1", best_sad1, ALL_ONES);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < N; k++) sadv[k] = 100 - k;
        run_main("descending", 1'b0);
        do_ack("descending");

        for (int k = 0; k < N; k++) sadv[k] = 50;
        sadv[7] = 12;
        sadv[9] = 12;
        run_main("tie", 1'b0);
        do_ack("tie");

        for (int k = 0; k < N; k++) sadv[k] = ALL_ONES;
        run_main("all_ones", 1'b0);
        do_ack("all_ones");

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N; k++) sadv[k] = int'($urandom_range(0, ALL_ONES));
            run_main("random", 1'b0);
            do_ack("random");
        end
        for (int k = 0; k < N; k++) sadv[k] = int'($urandom_range(0, 3));
        run_main("random_ties", 1'b0);
        do_ack("random_ties");

        for (int k = 0; k < N; k++) sadv[k] = int'($urandom_range(0, 999));
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        n = 0;
        while (!(sad_en && cand_idx == 4'd5) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reached", cand_idx, 5);
        rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_sad_en", sad_en, 0);
        check("midrst_best_sad", best_sad, ALL_ONES);
        check("midrst_best_idx", best_idx, 0);
        check("midrst_cand_idx", cand_idx, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_idle_busy", busy, 0);
        check("midrst_idle_sad_en", sad_en, 0);
        run_main("post_rst", 1'b0);
        do_ack("post_rst");

        for (int k = 0; k < N; k++) sadv[k] = int'($urandom_range(0, ALL_ONES));
        run_main("hold_init", 1'b1);
        repeat (3) @(negedge clk);
        check("hold_init_done", done, 1);
        check("hold_init_busy", busy, 0);
        init = 1'b0;
        do_ack("hold_init");
        ack = 1'b1;
        repeat (3) @(negedge clk);
        ack = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_ack_busy", busy, 0);
        check("idle_ack_done", done, 0);
        check("one_search_pulses", rst_pulses, 1);

        @(negedge clk);
        init1 = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        init1 = 1'b0;
        while (!done1 && n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("single_latency", n, 4);
        check("single_best_sad", best_sad1, 42);
        check("single_best_idx", best_idx1, 0);
        check("single_cand_idx", cand_idx1, 0);
        ack1 = 1'b1;
        @(negedge clk);
        ack1 = 1'b0;
        check("single_ack_done", done1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sad_search_ctrl.md
SAD_SEARCH_CTRL -- requirements
Module: sad_search_ctrl

Interface
REQ-001 Parameter WIDTH, 8, pixel width of the SAD datapath.
REQ-002 Parameter NUM_CAND, 16, candidate blocks per search (range 1..256).
REQ-003 Parameter PIPE_LAT, 3, cycles from a datapath enable cycle to its valid SAD on sad_in (range 1..8).
REQ-004 Parameter SAD_W, WIDTH+5, SAD result width.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 init  input  1  start-search request, sampled only in IDLE.
REQ-008 ack  input  1  result acknowledge, sampled only in DONE.
REQ-009 sad_in  input  SAD_W  SAD result from the datapath.
REQ-010 sad_en  output  1  datapath pipeline enable.
REQ-011 sad_rst  output  1  datapath clear; active-high, one cycle.
REQ-012 cand_idx  output  clog2(NUM_CAND) (min 1)  candidate index presented to the candidate store.
REQ-013 busy  output  1  high in every state except IDLE and DONE.
REQ-014 done  output  1  high only in DONE.
REQ-015 best_sad  output  SAD_W  minimum SAD found.
REQ-016 best_idx  output  clog2(NUM_CAND)  index of best_sad.

Function
REQ-017 States SHALL be IDLE, CLEAR, ISSUE, DRAIN and DONE; all outputs registered.
REQ-018 IDLE->CLEAR on init=1; otherwise IDLE holds; best_sad/best_idx retain their last values.
REQ-019 CLEAR SHALL last one cycle: sad_rst=1, sad_en=0, best_sad loaded to all-ones, best_idx to 0, cand_idx to 0; next state ISSUE.
REQ-020 ISSUE: sad_en=1; cand_idx SHALL increment by 1 per cycle from 0 to NUM_CAND-1; after the cycle with cand_idx=NUM_CAND-1, next state DRAIN.
REQ-021 Each ISSUE cycle SHALL push a valid tag carrying cand_idx into a PIPE_LAT-deep tag pipeline; the tag pipeline SHALL shift only when sad_en=1.
REQ-022 DRAIN: sad_en=1, no new valid tags pushed (bubbles); DRAIN SHALL last exactly PIPE_LAT cycles, then DONE.
REQ-023 On each cycle a valid tag exits the pipeline, sad_in SHALL be compared unsigned with best_sad; if strictly less, best_sad<=sad_in and best_idx<=tag index.
REQ-024 Ties SHALL keep the earlier (lower) index; a sad_in of all-ones on candidate 0 SHALL still be recorded with best_idx=0.
REQ-025 Latency: init sampled at cycle T -> done=1 from cycle T+2+NUM_CAND+PIPE_LAT.
REQ-026 DONE: done=1, sad_en=0, best outputs stable; DONE->IDLE on ack=1; init ignored in DONE.
REQ-027 init and ack outside their sampling states SHALL have no effect.
REQ-028 NUM_CAND=1 SHALL produce a one-cycle ISSUE with the same rules.
REQ-029 cand_idx SHALL hold NUM_CAND-1 during DRAIN and DONE (no wrap).

Reset
REQ-030 rst=0 SHALL immediately force IDLE, sad_en=0, sad_rst=0, busy=0, done=0, cand_idx=0, best_sad=all-ones, best_idx=0, and all tag valids=0, including mid-search.
REQ-031 After rst deasserts, the block SHALL wait in IDLE for a fresh init.

Structure
REQ-032 State encoding, SAD_W derivation and default NUM_CAND/PIPE_LAT SHALL live in shared package sad_pkg.
REQ-033 The valid/index tag pipeline SHALL be a separate sub-module sad_tag_pipe (parameters PIPE_LAT, index width; ports clk, rst, shift, in_valid, in_idx, out_valid, out_idx).

Verification
REQ-034 NUM_CAND=16, PIPE_LAT=3, SAD_k=100-k: init at T -> done at T+21, best_sad=85, best_idx=15.
REQ-035 SAD sequence all 50 except candidate 7 = 12 and candidate 9 = 12 -> best_sad=12, best_idx=7 (tie keeps lower).
REQ-036 All SAD = 8191 (all-ones, SAD_W=13) -> best_sad=8191, best_idx=0.
REQ-037 rst=0 during ISSUE at cand_idx=5 -> same-cycle busy=0, sad_en=0, best_sad=8191; init after release restarts from cand_idx=0 with full T+21 latency.
REQ-038 init held high through DONE and ack pulsed with init low -> exactly one search; ack in IDLE and init in DONE ignored; sad_rst high for exactly one cycle per search.
REQ-039 NUM_CAND=1, PIPE_LAT=1, SAD_0=42 -> done at T+4, best_sad=42, best_idx=0.
